// File: rtl/wm8731_cfg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wm8731_cfg_pkg
//  Description : Shared types and constants for the WM8731 I2C power-up
//                configuration sequencer: FSM state encoding, default device
//                address and the register word table.
//  Revision    : 1.0 - initial release
// ============================================================================
package wm8731_cfg_pkg;

   // Sequencer states, explicitly 3 bits wide
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_BIT   = 3'd2,
      ST_STOP  = 3'd3,
      ST_GAP   = 3'd4,
      ST_DONE  = 3'd5,
      ST_ERR   = 3'd6
   } cfg_state_t;

   // 7-bit address 0x1A with R/W = 0
   localparam logic [7:0] DEV_ADDR_DEFAULT = 8'h34;

   // Slot of the ACK bit inside each 9-slot byte frame
   localparam logic [3:0] ACK_SLOT  = 4'd8;
   // Index of the final byte of a word transaction
   localparam logic [1:0] LAST_BYTE = 2'd2;

   // Register words written in order after power-up
   function automatic logic [15:0] cfg_word(input logic [3:0] idx);
      logic [15:0] w;
      case (idx)
         4'd0:    w = 16'h1E00;  // reset
         4'd1:    w = 16'h0017;  // left line in
         4'd2:    w = 16'h0217;  // right line in
         4'd3:    w = 16'h0812;  // analog path
         4'd4:    w = 16'h0A00;  // digital path
         4'd5:    w = 16'h0C00;  // power on
         4'd6:    w = 16'h0E42;  // I2S, 16-bit, master
         4'd7:    w = 16'h1000;  // 48 kHz normal mode
         4'd8:    w = 16'h1201;  // active
         default: w = 16'h0000;
      endcase
      return w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_phase_tick.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_phase_tick
//  Description : Divides clk into quarter-bit phase ticks and tracks the
//                2-bit phase P0..P3 of the current I2C bit. Held cleared
//                while the sequencer is idle so every transaction starts
//                on a fresh P0.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_phase_tick #(
   parameter int CLK_DIV = 25
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   output logic       tick,
   output logic [1:0] phase
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] C_DIV_LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] div_q, div_d;
   logic [1:0]    phase_q, phase_d;
   logic          tick_raw;

   assign tick_raw = (div_q == C_DIV_LAST);

   // Next divider / phase values; clear forces both back to the P0 origin
   always_comb begin
      div_d   = tick_raw ? '0 : (div_q + CW'(1));
      phase_d = tick_raw ? (phase_q + 2'd1) : phase_q;
      if (clear) begin
         div_d   = '0;
         phase_d = 2'd0;
      end
   end

   // Divider and phase registers
   always_ff @(posedge clk) begin
      if (reset) begin
         div_q   <= '0;
         phase_q <= 2'd0;
      end else begin
         div_q   <= div_d;
         phase_q <= phase_d;
      end
   end

   assign tick  = tick_raw && !clear;
   assign phase = phase_q;

endmodule
`default_nettype wire

// File: rtl/wm8731_i2c_config.sv
`default_nettype none
// ============================================================================
//  Module      : wm8731_i2c_config
//  Description : Power-up configuration sequencer for the WM8731 codec.
//                Sends each table word as a 3-byte I2C write (address,
//                data high, data low), checks every ACK, retries a word on
//                NACK and releases the bus when finished or on failure.
//  Revision    : 1.0 - initial release
// ============================================================================
module wm8731_i2c_config
   import wm8731_cfg_pkg::*;
#(
   parameter int         CLK_DIV   = 25,
   parameter int         NUM_WORDS = 9,
   parameter logic [7:0] DEV_ADDR  = DEV_ADDR_DEFAULT,
   parameter int         MAX_RETRY = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic       i2c_sclk,
   output logic       i2c_sdat_oe,
   input  logic       i2c_sdat_in,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic [3:0] word_idx
);

   localparam int RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [RW-1:0] C_RETRY_MAX = RW'(MAX_RETRY);
   localparam logic [3:0]    C_WORD_LAST = 4'(NUM_WORDS - 1);

   cfg_state_t     state_q, state_d;
   logic [3:0]     bit_q, bit_d;
   logic [1:0]     byte_q, byte_d;
   logic [3:0]     word_idx_q, word_idx_d;
   logic [RW-1:0]  retry_q, retry_d;
   logic           nack_q, nack_d;
   logic           sclk_q, sclk_d;
   logic           sdat_oe_q, sdat_oe_d;

   logic           tick;
   logic [1:0]     phase;
   logic           bus_idle;
   logic           bit_end;
   logic           ack_sample;
   logic [15:0]    cur_word;
   logic [7:0]     tx_byte;

   assign bus_idle   = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR);
   assign bit_end    = tick && (phase == 2'd3);
   // ACK is taken on the clock that enters P3, well after SCLK has risen
   assign ack_sample = tick && (phase == 2'd2);
   assign cur_word   = cfg_word(word_idx_q);

   i2c_phase_tick #(
      .CLK_DIV (CLK_DIV)
   ) u_phase_tick (
      .clk   (clk),
      .reset (reset),
      .clear (bus_idle),
      .tick  (tick),
      .phase (phase)
   );

   // State and bus output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         bit_q      <= 4'd0;
         byte_q     <= 2'd0;
         word_idx_q <= 4'd0;
         retry_q    <= '0;
         nack_q     <= 1'b0;
         sclk_q     <= 1'b1;
         sdat_oe_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_q      <= bit_d;
         byte_q     <= byte_d;
         word_idx_q <= word_idx_d;
         retry_q    <= retry_d;
         nack_q     <= nack_d;
         sclk_q     <= sclk_d;
         sdat_oe_q  <= sdat_oe_d;
      end
   end

   // Next-state logic: every bus state lasts whole bit periods
   always_comb begin
      state_d    = state_q;
      bit_d      = bit_q;
      byte_d     = byte_q;
      word_idx_d = word_idx_q;
      retry_d    = retry_q;
      nack_d     = nack_q;
      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start) begin
               state_d    = ST_START;
               word_idx_d = 4'd0;
               retry_d    = '0;
               nack_d     = 1'b0;
            end
         end
         ST_START: begin
            nack_d = 1'b0;
            if (bit_end) begin
               state_d = ST_BIT;
               bit_d   = 4'd0;
               byte_d  = 2'd0;
            end
         end
         ST_BIT: begin
            if (ack_sample && (bit_q == ACK_SLOT)) begin
               nack_d = i2c_sdat_in;
            end
            if (bit_end) begin
               if (bit_q == ACK_SLOT) begin
                  // A NACK abandons the rest of the word immediately
                  if (nack_q || (byte_q == LAST_BYTE)) begin
                     state_d = ST_STOP;
                  end else begin
                     byte_d = byte_q + 2'd1;
                     bit_d  = 4'd0;
                  end
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               state_d = ST_GAP;
            end
         end
         ST_GAP: begin
            if (bit_end) begin
               if (nack_q) begin
                  if (retry_q < C_RETRY_MAX) begin
                     retry_d = retry_q + RW'(1);
                     state_d = ST_START;
                  end else begin
                     state_d = ST_ERR;
                  end
               end else if (word_idx_q < C_WORD_LAST) begin
                  word_idx_d = word_idx_q + 4'd1;
                  retry_d    = '0;
                  state_d    = ST_START;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Bus waveform per state/phase and status flags
   always_comb begin
      sclk_d    = 1'b1;
      sdat_oe_d = 1'b0;
      case (byte_q)
         2'd1:    tx_byte = cur_word[15:8];
         2'd2:    tx_byte = cur_word[7:0];
         default: tx_byte = DEV_ADDR;
      endcase
      case (state_q)
         ST_START: begin
            // SDAT falls in P1 with SCLK high, SCLK falls in P2
            sclk_d    = ~phase[1];
            sdat_oe_d = (phase != 2'd0);
         end
         ST_BIT: begin
            sclk_d    = phase[1];
            sdat_oe_d = (bit_q != ACK_SLOT) && !tx_byte[3'd7 - bit_q[2:0]];
         end
         ST_STOP: begin
            // SDAT held low until SCLK is high, then released in P3
            sclk_d    = phase[1];
            sdat_oe_d = (phase != 2'd3);
         end
         default: begin
            sclk_d    = 1'b1;
            sdat_oe_d = 1'b0;
         end
      endcase
      busy  = !bus_idle;
      done  = (state_q == ST_DONE);
      error = (state_q == ST_ERR);
   end

   assign i2c_sclk    = sclk_q;
   assign i2c_sdat_oe = sdat_oe_q;
   assign word_idx    = word_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_wm8731_i2c_config.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wm8731_i2c_config
//  Description : Testbench for wm8731_i2c_config. An I2C slave model decodes
//                the bus, acknowledges (or refuses) bytes and hands each
//                finished transaction to a scoreboard of expected writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wm8731_i2c_config;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       i2c_sclk;
   logic       i2c_sdat_oe;
   logic       i2c_sdat_in;
   logic       busy;
   logic       done;
   logic       error;
   logic [3:0] word_idx;

   logic       slave_pull = 1'b0;
   logic       sdat;

   // Open-drain pad: low if either side pulls
   assign sdat        = ~(i2c_sdat_oe | slave_pull);
   assign i2c_sdat_in = sdat;

   always #5 clk = ~clk;

   wm8731_i2c_config dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .i2c_sclk    (i2c_sclk),
      .i2c_sdat_oe (i2c_sdat_oe),
      .i2c_sdat_in (i2c_sdat_in),
      .busy        (busy),
      .done        (done),
      .error       (error),
      .word_idx    (word_idx)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Expected transaction: {byte count, byte0, byte1, byte2}
   logic [27:0] exp_q[$];
   logic [15:0] cfg_tbl [9] = '{16'h1E00, 16'h0017, 16'h0217, 16'h0812, 16'h0A00,
                                16'h0C00, 16'h0E42, 16'h1000, 16'h1201};

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic check_range(input string name, input int got, input int lo, input int hi);
      n_checks++;
      if (got < lo || got > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, got, lo, hi);
      end
   endtask

   task automatic push_word(input int i);
      exp_q.push_back({4'd3, 8'h34, cfg_tbl[i]});
   endtask

   // ------------------------------------------------------------------
   // Slave model + monitor: decodes START/STOP/bits, ACKs per nack_mode,
   // checks SCLK pulse widths and pops the scoreboard on every STOP.
   // nack_mode: 0 = always ACK, 1 = NACK data-high of 4th transaction,
   //            2 = NACK every address byte
   // ------------------------------------------------------------------
   int          nack_mode = 0;
   int          tr_base   = 0;
   int          tr_idx    = 0;
   int          terr      = 0;
   int          run_len   = 1;
   int          bitc      = 0;
   int          nb        = 0;
   int          exp_low;
   logic        sclk_prev = 1'b1;
   logic        sdat_prev = 1'b1;
   logic        in_frame  = 1'b0;
   logic        in_ack    = 1'b0;
   logic        first_fall = 1'b0;
   logic        first_low  = 1'b0;
   logic        nack_now;
   logic [7:0]  shreg = 8'h00;
   logic [7:0]  gb0, gb1, gb2;
   logic [27:0] got_tr;
   logic [27:0] exp_tr;
   logic        s_now, d_now;

   initial begin
      forever begin
         @(negedge clk);
         s_now = i2c_sclk;
         d_now = sdat;
         if (reset) begin
            in_frame   = 1'b0;
            in_ack     = 1'b0;
            bitc       = 0;
            slave_pull = 1'b0;
            run_len    = 1;
         end else begin
            if (s_now && sclk_prev && sdat_prev && !d_now) begin
               if (in_frame) terr++;
               in_frame   = 1'b1;
               tr_idx++;
               bitc       = 0;
               nb         = 0;
               in_ack     = 1'b0;
               first_fall = 1'b1;
               first_low  = 1'b1;
               gb0 = 8'h00; gb1 = 8'h00; gb2 = 8'h00;
            end else if (s_now && sclk_prev && !sdat_prev && d_now) begin
               // STOP's own SCLK rise sampled one bit, hence bitc == 1
               if (!in_frame || bitc != 1 || in_ack) terr++;
               if (in_frame) begin
                  got_tr = {4'(nb), gb0, gb1, gb2};
                  if (exp_q.size() == 0) begin
                     n_checks++;
                     n_fail++;
                     $display("FAIL txn_unexpected: got %0h, expected none", got_tr);
                  end else begin
                     exp_tr = exp_q.pop_front();
                     check("txn", 32'(got_tr), 32'(exp_tr));
                  end
               end
               in_frame = 1'b0;
            end
            if (s_now != sclk_prev) begin
               if (in_frame) begin
                  if (s_now) begin
                     exp_low   = first_low ? 100 : 50;
                     first_low = 1'b0;
                     if (run_len != exp_low) terr++;
                     if (bitc < 8) begin
                        shreg = {shreg[6:0], d_now};
                        bitc++;
                     end
                  end else begin
                     if (!first_fall && run_len != 50) terr++;
                     first_fall = 1'b0;
                     if (in_ack) begin
                        slave_pull = 1'b0;
                        in_ack     = 1'b0;
                        bitc       = 0;
                     end else if (bitc == 8) begin
                        if (nb == 0) gb0 = shreg;
                        else if (nb == 1) gb1 = shreg;
                        else gb2 = shreg;
                        nack_now = (nack_mode == 2) ||
                                   (nack_mode == 1 && (tr_idx - tr_base) == 4 && nb == 1);
                        nb++;
                        in_ack     = 1'b1;
                        slave_pull = !nack_now;
                     end
                  end
               end
               run_len = 1;
            end else begin
               run_len++;
            end
         end
         sclk_prev = s_now;
         sdat_prev = d_now;
      end
   end

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   int n;
   int idle_bad;
   int tr_snap;

   task automatic pulse_start;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic watch_idle(input int cycles);
      idle_bad = 0;
      tr_snap  = tr_idx;
      repeat (cycles) begin
         @(negedge clk);
         if (i2c_sclk !== 1'b1 || i2c_sdat_oe !== 1'b0 || busy !== 1'b0) idle_bad++;
      end
      if (tr_idx != tr_snap) idle_bad++;
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_sclk",     32'(i2c_sclk),    32'd1);
      check("rst_sdat_oe",  32'(i2c_sdat_oe), 32'd0);
      check("rst_busy",     32'(busy),        32'd0);
      check("rst_done",     32'(done),        32'd0);
      check("rst_error",    32'(error),       32'd0);
      check("rst_word_idx", 32'(word_idx),    32'd0);
      // start together with reset must be ignored
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("rst_wins_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Test 1: clean sequence, extra start pulses while busy
      nack_mode = 0;
      tr_base   = tr_idx;
      for (int i = 0; i < 9; i++) push_word(i);
      pulse_start();
      n = 0;
      while (!done && n < 30000) begin
         @(negedge clk);
         n++;
         start = (n == 500 || n == 5000 || n == 20000) ? 1'b1 : 1'b0;
      end
      start = 1'b0;
      check_range("done_latency", n, 26996, 27004);
      check("t1_done",     32'(done),     32'd1);
      check("t1_error",    32'(error),    32'd0);
      check("t1_word_idx", 32'(word_idx), 32'd8);
      check("t1_txn_cnt",  32'(tr_idx - tr_base), 32'd9);
      check("t1_pending",  32'(exp_q.size()), 32'd0);
      watch_idle(200);
      check("t1_bus_idle", 32'(idle_bad), 32'd0);
      check("t1_timing",   32'(terr),     32'd0);

      // Test 2: restart after DONE, single NACK on word 3 data-high byte
      nack_mode = 1;
      tr_base   = tr_idx;
      for (int i = 0; i < 3; i++) push_word(i);
      exp_q.push_back({4'd2, 8'h34, 8'h08, 8'h00});
      for (int i = 3; i < 9; i++) push_word(i);
      pulse_start();
      check("t2_done_drop", 32'(done), 32'd0);
      check("t2_busy",      32'(busy), 32'd1);
      n = 0;
      while (!done && n < 35000) begin
         @(negedge clk);
         n++;
      end
      check("t2_done",    32'(done),  32'd1);
      check("t2_error",   32'(error), 32'd0);
      check("t2_txn_cnt", 32'(tr_idx - tr_base), 32'd10);
      check("t2_pending", 32'(exp_q.size()), 32'd0);
      check("t2_timing",  32'(terr), 32'd0);

      // Test 3: persistent NACK from word 0
      nack_mode = 2;
      tr_base   = tr_idx;
      for (int i = 0; i < 4; i++) exp_q.push_back({4'd1, 8'h34, 16'h0000});
      pulse_start();
      n = 0;
      while (!error && n < 10000) begin
         @(negedge clk);
         n++;
      end
      check("t3_error",    32'(error),       32'd1);
      check("t3_busy",     32'(busy),        32'd0);
      check("t3_done",     32'(done),        32'd0);
      check("t3_word_idx", 32'(word_idx),    32'd0);
      check("t3_sclk",     32'(i2c_sclk),    32'd1);
      check("t3_sdat_oe",  32'(i2c_sdat_oe), 32'd0);
      watch_idle(300);
      check("t3_bus_idle", 32'(idle_bad), 32'd0);
      check("t3_attempts", 32'(tr_idx - tr_base), 32'd4);
      check("t3_pending",  32'(exp_q.size()), 32'd0);
      check("t3_error_held", 32'(error), 32'd1);

      // Test 4: start after error, then reset mid-byte of word 5
      nack_mode = 0;
      tr_base   = tr_idx;
      for (int i = 0; i < 9; i++) push_word(i);
      pulse_start();
      check("t4_error_clr", 32'(error), 32'd0);
      check("t4_busy",      32'(busy),  32'd1);
      n = 0;
      while (word_idx != 4'd5 && n < 20000) begin
         @(negedge clk);
         n++;
      end
      repeat (1000) @(negedge clk);
      check("t4_pending_w5", 32'(exp_q.size()), 32'd4);
      check("t4_timing",     32'(terr), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check("t4_rst_sclk",     32'(i2c_sclk),    32'd1);
      check("t4_rst_sdat_oe",  32'(i2c_sdat_oe), 32'd0);
      check("t4_rst_busy",     32'(busy),        32'd0);
      check("t4_rst_word_idx", 32'(word_idx),    32'd0);
      @(negedge clk);
      reset = 1'b0;
      watch_idle(1000);
      check("t4_no_activity", 32'(idle_bad), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/wm8731_i2c_config.md
Name: wm8731_i2c_config

Overview:
- Power-up configuration sequencer for the WM8731 audio codec over I2C.
- Walks a fixed table of 16-bit register words. Each word is sent as one 3-byte I2C write: device address, then data high byte, then data low byte.
- Checks the ACK after every byte and retries a word on NACK.
- Sits beside the audio datapath in exp3. It drives I2C_SCLK and the open-drain I2C_SDAT. It releases the bus once configuration is complete.

Parameters:
- CLK_DIV, 25: clocks per quarter bit. Bit period = 4*CLK_DIV = 100 clocks = 2000 ns at 50 MHz.
- NUM_WORDS, 9: number of table entries sent.
- DEV_ADDR, 8'h34: write address byte (7-bit address 0x1A, R/W=0).
- MAX_RETRY, 3: retries allowed per word after its first attempt.

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse that begins the sequence
- i2c_sclk  out  1  I2C clock, push-pull
- i2c_sdat_oe  out  1  1 = pull SDAT low, 0 = release (pad tristate outside)
- i2c_sdat_in  in  1  sampled SDAT pad value
- busy  out  1  sequence in progress
- done  out  1  all words acknowledged; held until the next start
- error  out  1  retry limit exceeded; held until the next start or reset
- word_idx  out  4  index of the word in flight or last completed

Behaviour:
- Clock and reset:
  - Single clock domain, clk.
  - reset is synchronous and active-high.
  - Reset values: i2c_sclk=1, i2c_sdat_oe=0, busy=0, done=0, error=0, word_idx=0, retry count=0, FSM=IDLE, phase counter=0.
- Bit timing:
  - A phase tick fires every CLK_DIV clocks. Each bit has 4 phases, P0..P3.
  - SCLK is low in P0–P1 and high in P2–P3.
  - SDAT changes only at P0 entry.
  - ACK is sampled on the clock when P3 begins. ACK = i2c_sdat_in==0.
- FSM states and transitions:
  - IDLE: bus released. start → START, busy=1, done=0, error=0, word_idx=0.
  - START: one bit period. SDAT low at P1 while SCLK is still high from idle, then SCLK low. Next → BIT, bit count=0.
  - BIT: 27 bit slots.
    - Byte order: DEV_ADDR, word[15:8], word[7:0]. Each byte is 8 data bits MSB first, then an ACK slot with SDAT released.
    - A data 1 releases SDAT (oe=0). A data 0 sets oe=1.
    - NACK at any ACK slot → STOP with the nack flag set. The remaining bits are skipped.
  - STOP: one bit period. SDAT low at P0–P1, SCLK high at P2, SDAT released at P3.
  - GAP: one bit period, bus idle. Then:
    - If nack and retry < MAX_RETRY: retry+1, resend the same word (START).
    - If nack and retry == MAX_RETRY: → ERR.
    - If no nack and word_idx < NUM_WORDS-1: word_idx+1, retry=0, → START.
    - Otherwise → DONE.
  - DONE: busy=0, done=1, bus released. start → restart from word 0.
  - ERR: busy=0, error=1, bus released. word_idx stays at the failing word. start → restart from word 0.
- Latency:
  - One clean word = 30 bit periods = 3000 clocks at the defaults.
  - Full clean sequence = 27000 clocks from the start pulse to done rising.
- Boundary conditions:
  - start while busy is ignored.
  - start and reset in the same cycle: reset wins.
  - Reset mid-transaction: the bus is released in the next cycle, without a STOP. Firmware re-pulses start.
  - i2c_sdat_in is sampled only at ACK slots. No arbitration or clock stretching is supported.

Decomposition:
- Package wm8731_cfg_pkg holds:
  - The state enum.
  - DEV_ADDR_DEFAULT.
  - The config table: 16'h1E00 (reset), 16'h0017 (L line in), 16'h0217 (R line in), 16'h0812 (analog path), 16'h0A00 (digital path), 16'h0C00 (power on), 16'h0E42 (I2S, 16-bit, master), 16'h1000 (48 kHz normal), 16'h1201 (active).
- Sub-module i2c_phase_tick: clock divider producing the phase tick and the 2-bit phase. Synchronous clear on reset or on leaving IDLE.

Test Plan:
- ACK-always slave model, one start pulse:
  - Decoded bytes are 34 1E 00, 34 00 17, … 34 12 01 (27 bytes).
  - done rises 27000±4 clocks after start; error=0; word_idx=8.
- Timing checks:
  - SCLK high and low each last 50 clocks.
  - SDAT never toggles while SCLK is high, except START (fall) and STOP (rise).
  - The bus is idle-high after DONE.
- Single NACK on the data-high ACK of word 3:
  - Word 3 is re-sent in full after STOP+GAP.
  - 10 transactions total; done=1, error=0.
- Persistent NACK from word 0:
  - Exactly 4 attempts are made, then error=1, busy=0, word_idx=0, bus released.
  - A subsequent start clears error and restarts.
- Reset asserted mid-byte of word 5:
  - Next cycle: i2c_sclk=1, i2c_sdat_oe=0, busy=0, word_idx=0.
  - No activity until start.
- start pulsed repeatedly while busy: no restart, word sequence unchanged. start after DONE: done drops and the sequence repeats from word 0.
